// File: rtl/ste_shift_pkg.sv
// ste_shift_pkg: shared width defaults and counter-width helper for the shift register
package ste_shift_pkg;
    localparam int STE_SHIFT_W_DEFAULT = 24;
    function automatic int ste_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/ste_shift_cnt.sv
// ste_shift_cnt: saturating shift counter with word-complete flag (used under STE_SHIFT_CNT_EN)
module ste_shift_cnt
    import ste_shift_pkg::*;
#(
    parameter int SHIFT_W = STE_SHIFT_W_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset_i,
    input  logic                            clr_i,
    input  logic                            en_i,
    output logic [ste_cnt_w(SHIFT_W)-1:0]   cnt_o,
    output logic                            done_o
);
    localparam int CW = ste_cnt_w(SHIFT_W);
    localparam logic [CW-1:0] CNT_MAX = CW'(SHIFT_W);
    logic [CW-1:0] cnt_d;
    assign done_o = cnt_o == CNT_MAX;
    // Saturation keeps done high across extra shifts until the next clear or load
    always_comb cnt_d = clr_i ? '0 : (en_i && !done_o) ? cnt_o + 1'b1 : cnt_o;
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) cnt_o <= '0;
        else         cnt_o <= cnt_d;
    end
endmodule

// File: rtl/ste_shift_register.sv
// ste_shift_register: MSB-first serial/parallel shift register; STE_SHIFT_CNT_EN adds shift count and done flag
module ste_shift_register
    import ste_shift_pkg::*;
#(
    parameter int SHIFT_W = STE_SHIFT_W_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset_i,
    input  logic                            din_i,
    input  logic [SHIFT_W-1:0]              din_parallel_i,
    input  logic                            shift_clr_i,
    input  logic                            shift_en_i,
    input  logic                            shift_ld_i,
    output logic                            dout_o,
    output logic [SHIFT_W-1:0]              dout_parallel_o
`ifdef STE_SHIFT_CNT_EN
    ,
    output logic [ste_cnt_w(SHIFT_W)-1:0]   shift_cnt_o,
    output logic                            shift_done_o
`endif
);
    logic [SHIFT_W-1:0] sr, sr_d;
    always_comb sr_d = shift_clr_i ? '0 :
                       shift_ld_i  ? din_parallel_i :
                       shift_en_i  ? {sr[SHIFT_W-2:0], din_i} : sr;
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) sr <= '0;
        else         sr <= sr_d;
    end
    assign dout_o          = sr[SHIFT_W-1];
    assign dout_parallel_o = sr;
`ifdef STE_SHIFT_CNT_EN
    ste_shift_cnt #(.SHIFT_W(SHIFT_W)) u_cnt (
        .clk     (clk),
        .reset_i (reset_i),
        .clr_i   (shift_clr_i | shift_ld_i),
        .en_i    (shift_en_i),
        .cnt_o   (shift_cnt_o),
        .done_o  (shift_done_o)
    );
`endif
endmodule

// File: tb/tb_ste_shift_register.sv
// tb_ste_shift_register: scoreboard bench for ste_shift_register at SHIFT_W=24
module tb_ste_shift_register;
    import ste_shift_pkg::*;
    localparam int W = 24;
    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic din_i = 1'b0;
    logic [W-1:0] din_parallel_i = '0;
    logic shift_clr_i = 1'b0, shift_en_i = 1'b0, shift_ld_i = 1'b0;
    logic dout_o;
    logic [W-1:0] dout_parallel_o;
    int checks = 0;
    int errors = 0;
    logic [W-1:0] m = '0;
    logic [W-1:0] q[$];
    logic [W-1:0] exp_v;
    logic [W-1:0] words[7] = '{24'h000001, 24'haaaaaa, 24'h555555, 24'hffffff,
                               24'h234567, 24'hdfeabc, 24'h111111};
    logic [W-1:0] w;
`ifdef STE_SHIFT_CNT_EN
    logic [ste_cnt_w(W)-1:0] shift_cnt_o;
    logic shift_done_o;
    int cnt_m = 0;
    int cq[$];
    int exp_c;
`endif
    always #5 clk = ~clk;
    ste_shift_register #(.SHIFT_W(W)) dut (
        .clk             (clk),
        .reset_i         (reset_i),
        .din_i           (din_i),
        .din_parallel_i  (din_parallel_i),
        .shift_clr_i     (shift_clr_i),
        .shift_en_i      (shift_en_i),
        .shift_ld_i      (shift_ld_i),
        .dout_o          (dout_o),
        .dout_parallel_o (dout_parallel_o)
`ifdef STE_SHIFT_CNT_EN
        ,
        .shift_cnt_o     (shift_cnt_o),
        .shift_done_o    (shift_done_o)
`endif
    );
    task automatic chk_par(input string tag, input logic [W-1:0] e);
        checks++;
        assert (dout_parallel_o === e) else begin
            errors++;
            $error("FAIL %s par obs=%h exp=%h", tag, dout_parallel_o, e);
        end
        checks++;
        assert (dout_o === e[W-1]) else begin
            errors++;
            $error("FAIL %s dout obs=%b exp=%b", tag, dout_o, e[W-1]);
        end
    endtask
`ifdef STE_SHIFT_CNT_EN
    task automatic chk_cnt(input string tag, input int e);
        checks++;
        assert (shift_cnt_o === ($bits(shift_cnt_o))'(e) && shift_done_o === (e == W)) else begin
            errors++;
            $error("FAIL %s cnt obs=%0d/%b exp=%0d/%b", tag, shift_cnt_o, shift_done_o, e, e == W);
        end
    endtask
`endif
    // Drive one cycle of controls, push the model's prediction, then compare after the edge
    task automatic step(input string tag, input logic c, input logic l, input logic e,
                        input logic d, input logic [W-1:0] p);
        shift_clr_i = c; shift_ld_i = l; shift_en_i = e; din_i = d; din_parallel_i = p;
        m = c ? '0 : l ? p : e ? {m[W-2:0], d} : m;
        q.push_back(m);
`ifdef STE_SHIFT_CNT_EN
        cnt_m = (c || l) ? 0 : (e && cnt_m < W) ? cnt_m + 1 : cnt_m;
        cq.push_back(cnt_m);
`endif
        @(posedge clk);
        #1;
        exp_v = q.pop_front();
        chk_par(tag, exp_v);
`ifdef STE_SHIFT_CNT_EN
        exp_c = cq.pop_front();
        chk_cnt(tag, exp_c);
`endif
    endtask
    task automatic send(input string tag, input logic [W-1:0] word);
        for (int i = W - 1; i >= 0; i--) step(tag, 1'b0, 1'b0, 1'b1, word[i], W'($urandom));
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_par("reset", '0);
`ifdef STE_SHIFT_CNT_EN
        chk_cnt("reset", 0);
`endif
        reset_i = 1'b0;
        foreach (words[k]) begin
            w = words[k];
            send("word", w);
            chk_par("word_final", w);
        end
        for (int i = 0; i < 5; i++) step("hold", 1'b0, 1'b0, 1'b0, 1'($urandom), W'($urandom));
        chk_par("hold_final", 24'h111111);
        send("b2b", 24'hffffff);
        chk_par("b2b_final", 24'hffffff);
        step("clr", 1'b1, 1'b0, 1'b0, 1'b1, W'($urandom));
        chk_par("clr_const", 24'h000000);
        send("refill", 24'hdfeabc);
        step("clr_ld_en", 1'b1, 1'b1, 1'b1, 1'b1, 24'hffffff);
        chk_par("clr_ld_en_const", 24'h000000);
        step("ld", 1'b0, 1'b1, 1'b0, 1'b0, 24'ha5aa5a);
        chk_par("ld_const", 24'ha5aa5a);
        step("ld_shift", 1'b0, 1'b0, 1'b1, 1'b0, W'($urandom));
        chk_par("ld_shift_const", 24'h4b54b4);
        step("ld_en", 1'b0, 1'b1, 1'b1, 1'b1, 24'h123456);
        chk_par("ld_en_const", 24'h123456);
`ifdef STE_SHIFT_CNT_EN
        step("cnt_ld", 1'b0, 1'b1, 1'b0, 1'b0, 24'h000000);
        for (int i = 0; i < 23; i++) step("cnt_shift", 1'b0, 1'b0, 1'b1, 1'($urandom), W'($urandom));
        chk_cnt("cnt23", 23);
        step("cnt_24", 1'b0, 1'b0, 1'b1, 1'b1, W'($urandom));
        chk_cnt("cnt24", 24);
        for (int i = 0; i < 3; i++) step("cnt_sat", 1'b0, 1'b0, 1'b1, 1'b0, W'($urandom));
        chk_cnt("cnt_sat", 24);
        step("cnt_clr", 1'b1, 1'b0, 1'b0, 1'b0, W'($urandom));
        chk_cnt("cnt_clr", 0);
`endif
        // Asynchronous reset in the middle of a word
        for (int i = W - 1; i >= 12; i--) begin
            w = 24'h234567;
            step("pre_rst", 1'b0, 1'b0, 1'b1, w[i], W'($urandom));
        end
        #1 reset_i = 1'b1;
        #1;
        chk_par("async_rst", '0);
`ifdef STE_SHIFT_CNT_EN
        chk_cnt("async_rst", 0);
        cnt_m = 0;
`endif
        m = '0;
        @(posedge clk);
        #1 reset_i = 1'b0;
        send("post_rst", 24'h234567);
        chk_par("post_rst_final", 24'h234567);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
